// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - key event bundle from the PS/2 decoder to the game control logic
interface ps2_key_decoder_if;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       key_down;
    logic       key_enter;
    logic       key_esc;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output key_valid, key_code, key_ext, key_release,
        output key_left, key_right, key_up, key_down, key_enter, key_esc,
        output parity_err, frame_err
    );

    modport slave (
        input key_valid, key_code, key_ext, key_release,
        input key_left, key_right, key_up, key_down, key_enter, key_esc,
        input parity_err, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver: sync, clock filter, frame check, prefix strip, nav strobes
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    ps2_key_decoder_if.master     ev
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_clk;
    logic                  tick;

    state_t          state, state_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      shreg, sh_nxt;
    logic            par_bit, par_nxt;
    logic [CW-1:0]   idle_cnt, cnt_nxt;
    logic            timeout, byte_ok, perr_c, ferr_c;

    logic            ext_flag, brk_flag;
    logic            kv_q, ext_q, rel_q, pe_q, fe_q;
    logic [7:0]      code_q;
    logic [5:0]      nav_q;
    logic            ignored;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_sr  <= '1;
            filt_clk <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            dat_s1  <= ps2_data;
            dat_s2  <= dat_s1;
            filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
            if (&filt_sr)
                filt_clk <= 1'b1;
            else if (~|filt_sr)
                filt_clk <= 1'b0;
        end
    end

    // Tick is the single cycle in which the filtered clock is about to drop.
    assign tick = filt_clk && (~|filt_sr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= sh_nxt;
            par_bit  <= par_nxt;
            idle_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        sh_nxt      = shreg;
        par_nxt     = par_bit;
        byte_ok     = 1'b0;
        perr_c      = 1'b0;
        ferr_c      = 1'b0;
        cnt_nxt     = tick ? '0 : ((idle_cnt == TMO) ? idle_cnt : idle_cnt + 1'b1);
        timeout     = (state != S_IDLE) && (cnt_nxt == TMO);
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!dat_s2) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        ferr_c = 1'b1;
                    end
                end
                S_DATA: begin
                    sh_nxt      = {dat_s2, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = S_PARITY;
                end
                S_PARITY: begin
                    par_nxt   = dat_s2;
                    state_nxt = S_STOP;
                end
                default: begin
                    state_nxt = S_IDLE;
                    // A bad stop bit outranks a parity failure.
                    if (!dat_s2)
                        ferr_c = 1'b1;
                    else if (!(^{shreg, par_bit}))
                        perr_c = 1'b1;
                    else
                        byte_ok = 1'b1;
                end
            endcase
        end else if (timeout) begin
            state_nxt   = S_IDLE;
            ferr_c      = 1'b1;
            bit_cnt_nxt = '0;
            sh_nxt      = '0;
        end
    end

    always_comb begin
        case (shreg)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ignored = 1'b1;
            default:                                  ignored = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            kv_q     <= 1'b0;
            code_q   <= '0;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            nav_q    <= '0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            kv_q  <= 1'b0;
            nav_q <= '0;
            pe_q  <= perr_c;
            fe_q  <= ferr_c;
            if (perr_c || ferr_c) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_ok) begin
                if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (!ignored) begin
                        kv_q   <= 1'b1;
                        code_q <= shreg;
                        ext_q  <= ext_flag;
                        rel_q  <= brk_flag;
                        nav_q  <= {brk_flag && shreg == 8'h6B, brk_flag && shreg == 8'h74,
                                   brk_flag && shreg == 8'h75, brk_flag && shreg == 8'h72,
                                   brk_flag && shreg == 8'h5A, brk_flag && shreg == 8'h76};
                    end
                end
            end
        end
    end

    assign ev.key_valid   = kv_q;
    assign ev.key_code    = code_q;
    assign ev.key_ext     = ext_q;
    assign ev.key_release = rel_q;
    assign ev.key_left    = nav_q[5];
    assign ev.key_right   = nav_q[4];
    assign ev.key_up      = nav_q[3];
    assign ev.key_down    = nav_q[2];
    assign ev.key_enter   = nav_q[1];
    assign ev.key_esc     = nav_q[0];
    assign ev.parity_err  = pe_q;
    assign ev.frame_err   = fe_q;
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the PS/2 keyboard stream (ps2_clk/ps2_data) and turns it into single-cycle key events in the `clk` domain. It strips the E0/F0 prefixes and pulses dedicated navigation strobes (left/right/up/down/enter/esc) on key release. It sits directly upstream of the game control FSM and replaces the keyboard-clocked capture logic. All framing, parity and timeout checking is done here, so the game FSM only sees clean, validated events.

## Interface
- FILTER_LEN, 8: consecutive identical `clk` samples needed before the filtered ps2_clk changes level
- TIMEOUT_CYC, 200000: maximum `clk` cycles between bits inside a frame (2 ms at 100 MHz)
- clk  input  1  system clock; all logic on posedge
- rst  input  1  asynchronous, active-low reset
- ps2_clk  input  1  raw keyboard clock, asynchronous
- ps2_data  input  1  raw keyboard data, asynchronous
- key_valid  output  1  one-cycle pulse: key event available
- key_code  output  8  scan code of the event; held until the next event
- key_ext  output  1  event was E0-prefixed; held with key_code
- key_release  output  1  event was F0-prefixed (break); held with key_code
- key_left, key_right, key_up, key_down, key_enter, key_esc  output  1 each  one-cycle pulses on release of 6B, 74, 75, 72, 5A, 76 (key_ext ignored)
- parity_err  output  1  one-cycle pulse: frame dropped for bad parity
- frame_err  output  1  one-cycle pulse: frame dropped for bad start bit, bad stop bit or timeout

## Operation
- Synchronizer: 2-FF on ps2_clk and ps2_data.
- Filter: shift register of FILTER_LEN synced ps2_clk samples. The filtered clock goes to 1 only when all samples are 1, and to 0 only when all are 0; otherwise it holds.
- Bit tick: a filtered 1->0 transition. Synced ps2_data is sampled in that cycle.
- Frame FSM:
  - IDLE: on a tick, data=0 goes to DATA with bit count 0. Data=1 pulses frame_err and stays in IDLE.
  - DATA: 8 ticks, LSB first, into a shift register, then goes to PARITY.
  - PARITY: stores the bit, goes to STOP.
  - STOP: requires data=1 and odd parity over the 8 bits plus parity bit. If both hold, the byte is delivered to the prefix stage. If parity is wrong, pulse parity_err. If the stop bit is wrong, pulse frame_err; when both are wrong, only frame_err pulses. Return to IDLE in all cases.
- Timeout: an idle counter clears on every tick and saturates at TIMEOUT_CYC. Counter width is clog2(TIMEOUT_CYC+1). If it reaches TIMEOUT_CYC while not in IDLE: pulse frame_err, go to IDLE, discard the partial byte.
- Prefix stage, per delivered byte:
  - E0: set ext_flag, no event.
  - F0: set brk_flag, no event.
  - 00, AA, EE, FA, FE, FF: discarded, both flags cleared, no event.
  - Any other byte: key_valid=1, key_code=byte, key_ext=ext_flag, key_release=brk_flag; both flags cleared.
- Any parity_err or frame_err also clears ext_flag and brk_flag.
- Nav strobes fire in the same cycle as key_valid, and only when key_release=1 and the code matches.
- Reset (rst=0, at any time including mid-frame): FSM to IDLE, bit count, shift register, flags and timeout counter cleared. The filtered clock and filter samples are set to 1. All outputs are 0.

## Timing
- Tick latency: 2 sync + FILTER_LEN cycles after the raw ps2_clk falling edge.
- key_valid, nav strobes and error pulses rise 1 cycle after the stop-bit tick (registered outputs), and are high for exactly 1 cycle.
- key_code, key_ext and key_release update in the same cycle key_valid rises, then stay stable until the next event.
- At most one event per frame. A PS/2 frame takes at least ~660 us, so no back-pressure or buffering is required. The consumer must sample in the key_valid cycle.
- A timeout firing in the same cycle as a tick: the tick wins and the counter clears.

## Test plan
- Frame 1C, odd parity OK -> one key_valid, key_code=1C, key_ext=0, key_release=0, no nav strobe, no error pulses.
- Frames E0, F0, 75 -> exactly one key_valid: key_code=75, key_ext=1, key_release=1, key_up pulses in the same cycle. No events for the E0 or F0 frames.
- Frames F0, 5A with the parity bit of 5A inverted -> parity_err pulse, no key_valid, no key_enter. A following clean 5A -> key_valid with key_release=0, confirming brk_flag was cleared.
- Start bit, 4 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYC cycles after the last tick. A following clean F0, 6B -> key_left pulse.
- Raw ps2_clk low glitch of FILTER_LEN-2 cycles in the middle of a frame -> no extra bit, byte decoded correctly. Stop bit driven 0 -> frame_err, no key_valid.
- rst pulsed low after 5 bits of a frame -> all outputs 0 during reset. After release, the remainder of the interrupted frame is ignored or errors (as a frame_err), and the next full frame 76 after F0 -> key_esc pulse.
